// File: rtl/ex_operand_stage_if.sv
// Bundle between decode, the ID/EX register, the ALU and the M/W forwarding sources.
// The slave modport is the stage; the master modport is whatever drives it.
interface ex_operand_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
);
  logic [DATA_W-1:0] rd1D, rd2D, immD;
  logic [REG_AW-1:0] rs1D, rs2D, rdD;
  logic [1:0]        ALUOpD;
  logic [3:0]        ALUControlD;
  logic              ALUSrcD, branchD, regWriteD, memReadD, memWriteD;
  logic [DATA_W-1:0] aluResultM, resultW;
  logic [REG_AW-1:0] rdM, rdW;
  logic              regWriteM, regWriteW;
  logic              stallE, flushE;
  logic [DATA_W-1:0] input1, input2, writeDataE;
  logic [3:0]        ex_cmd;
  logic [1:0]        ALUOp;
  logic              branchE, regWriteE, memReadE, memWriteE, validE;
  logic [REG_AW-1:0] rdE;
  logic              loadUseStall;

  modport slave (
    input  rd1D, rd2D, immD, rs1D, rs2D, rdD, ALUOpD, ALUControlD, ALUSrcD,
           branchD, regWriteD, memReadD, memWriteD,
           aluResultM, rdM, regWriteM, resultW, rdW, regWriteW, stallE, flushE,
    output input1, input2, ex_cmd, ALUOp, branchE, regWriteE, memReadE, memWriteE,
           validE, rdE, writeDataE, loadUseStall
  );

  modport master (
    output rd1D, rd2D, immD, rs1D, rs2D, rdD, ALUOpD, ALUControlD, ALUSrcD,
           branchD, regWriteD, memReadD, memWriteD,
           aluResultM, rdM, regWriteM, resultW, rdW, regWriteW, stallE, flushE,
    input  input1, input2, ex_cmd, ALUOp, branchE, regWriteE, memReadE, memWriteE,
           validE, rdE, writeDataE, loadUseStall
  );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and
// load-use hazard detection (bubble insertion plus decode stall request).
module ex_operand_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input logic              clk,
  input logic              rst,
  ex_operand_stage_if.slave bus
);

  logic [DATA_W-1:0] rd1_q, rd2_q, imm_q;
  logic [REG_AW-1:0] rs1_q, rs2_q, rd_q;
  logic [1:0]        alu_op_q;
  logic [3:0]        ex_cmd_q;
  logic              alu_src_q, branch_q, reg_write_q, mem_read_q, mem_write_q, valid_q;

  logic              load_use;
  logic [DATA_W-1:0] fwd_a, fwd_b;

  // Both sources are compared: even an immediate-form consumer may use rs2 as store data.
  assign load_use = mem_read_q && (rd_q != '0) && ((rd_q == bus.rs1D) || (rd_q == bus.rs2D));

  always_ff @(posedge clk) begin
    if (rst || bus.flushE || (!bus.stallE && load_use)) begin
      rd1_q       <= '0;
      rd2_q       <= '0;
      imm_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      alu_op_q    <= '0;
      ex_cmd_q    <= '0;
      alu_src_q   <= 1'b0;
      branch_q    <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      valid_q     <= 1'b0;
    end else if (!bus.stallE) begin
      rd1_q       <= bus.rd1D;
      rd2_q       <= bus.rd2D;
      imm_q       <= bus.immD;
      rs1_q       <= bus.rs1D;
      rs2_q       <= bus.rs2D;
      rd_q        <= bus.rdD;
      alu_op_q    <= bus.ALUOpD;
      ex_cmd_q    <= bus.ALUControlD;
      alu_src_q   <= bus.ALUSrcD;
      branch_q    <= bus.branchD;
      reg_write_q <= bus.regWriteD;
      mem_read_q  <= bus.memReadD;
      mem_write_q <= bus.memWriteD;
      valid_q     <= 1'b1;
    end
  end

  // The younger producer (M) wins over W; register 0 is never forwarded.
  always_comb begin
    fwd_a = rd1_q;
    if (bus.regWriteM && (bus.rdM != '0) && (bus.rdM == rs1_q)) begin
      fwd_a = bus.aluResultM;
    end else if (bus.regWriteW && (bus.rdW != '0) && (bus.rdW == rs1_q)) begin
      fwd_a = bus.resultW;
    end
  end

  always_comb begin
    fwd_b = rd2_q;
    if (bus.regWriteM && (bus.rdM != '0) && (bus.rdM == rs2_q)) begin
      fwd_b = bus.aluResultM;
    end else if (bus.regWriteW && (bus.rdW != '0) && (bus.rdW == rs2_q)) begin
      fwd_b = bus.resultW;
    end
  end

  assign bus.input1       = fwd_a;
  assign bus.input2       = alu_src_q ? imm_q : fwd_b;
  assign bus.writeDataE   = fwd_b;
  assign bus.ex_cmd       = ex_cmd_q;
  assign bus.ALUOp        = alu_op_q;
  assign bus.branchE      = branch_q;
  assign bus.regWriteE    = reg_write_q;
  assign bus.memReadE     = mem_read_q;
  assign bus.memWriteE    = mem_write_q;
  assign bus.validE       = valid_q;
  assign bus.rdE          = rd_q;
  assign bus.loadUseStall = load_use;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Randomized and directed bench for ex_operand_stage against a reference model of
// the E-stage contents, with forwarding and load-use computed from those contents.
module tb_ex_operand_stage;

  typedef struct {
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [1:0]  op;
    logic [3:0]  cmd;
    logic        src, br, rw, mr, mw, v;
  } e_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail = 0;
  e_t   m;

  ex_operand_stage_if #(.DATA_W(32), .REG_AW(5)) b ();

  ex_operand_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  initial forever #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic e_t zero_e();
    e_t z;
    z = '{rd1: '0, rd2: '0, imm: '0, rs1: '0, rs2: '0, rd: '0, op: '0, cmd: '0,
          src: 1'b0, br: 1'b0, rw: 1'b0, mr: 1'b0, mw: 1'b0, v: 1'b0};
    return z;
  endfunction

  // Value the ALU should see for source register rs whose file value is rf.
  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rf);
    if (rs == 0) return rf;
    if (b.regWriteM && b.rdM == rs) return b.aluResultM;
    if (b.regWriteW && b.rdW == rs) return b.resultW;
    return rf;
  endfunction

  function automatic logic hazard();
    return m.mr && m.rd != 0 && (m.rd == b.rs1D || m.rd == b.rs2D);
  endfunction

  task automatic clear_inputs();
    b.rd1D = '0; b.rd2D = '0; b.immD = '0;
    b.rs1D = '0; b.rs2D = '0; b.rdD = '0;
    b.ALUOpD = '0; b.ALUControlD = '0;
    b.ALUSrcD = 0; b.branchD = 0; b.regWriteD = 0; b.memReadD = 0; b.memWriteD = 0;
    b.aluResultM = '0; b.rdM = '0; b.regWriteM = 0;
    b.resultW = '0; b.rdW = '0; b.regWriteW = 0;
    b.stallE = 0; b.flushE = 0;
  endtask

  task automatic rand_inputs();
    b.rd1D = $urandom; b.rd2D = $urandom; b.immD = $urandom;
    b.rs1D = 5'($urandom_range(0, 7)); b.rs2D = 5'($urandom_range(0, 7));
    b.rdD = 5'($urandom_range(0, 7));
    b.ALUOpD = 2'($urandom_range(0, 2)); b.ALUControlD = 4'($urandom);
    b.ALUSrcD = 1'($urandom); b.branchD = 1'($urandom); b.regWriteD = 1'($urandom);
    b.memReadD = ($urandom_range(0, 2) == 0); b.memWriteD = 1'($urandom);
    b.aluResultM = $urandom; b.rdM = 5'($urandom_range(0, 7)); b.regWriteM = 1'($urandom);
    b.resultW = $urandom; b.rdW = 5'($urandom_range(0, 7)); b.regWriteW = 1'($urandom);
    b.stallE = ($urandom_range(0, 4) == 0);
    b.flushE = ($urandom_range(0, 9) == 0);
  endtask

  // Check current outputs against the model, then advance both through one edge.
  task automatic step(input bit do_check);
    #1;
    if (do_check) begin
      check_eq("input1", b.input1, fwd(m.rs1, m.rd1));
      check_eq("input2", b.input2, m.src ? m.imm : fwd(m.rs2, m.rd2));
      check_eq("writeDataE", b.writeDataE, fwd(m.rs2, m.rd2));
      check_eq("loadUseStall", 32'(b.loadUseStall), 32'(hazard()));
      check_eq("ex_cmd", 32'(b.ex_cmd), 32'(m.cmd));
      check_eq("ALUOp", 32'(b.ALUOp), 32'(m.op));
      check_eq("rdE", 32'(b.rdE), 32'(m.rd));
      check_eq("ctrlE", 32'({b.branchE, b.regWriteE, b.memReadE, b.memWriteE, b.validE}),
               32'({m.br, m.rw, m.mr, m.mw, m.v}));
    end
    if (rst || b.flushE) m = zero_e();
    else if (b.stallE) m = m;
    else if (hazard()) m = zero_e();
    else m = '{rd1: b.rd1D, rd2: b.rd2D, imm: b.immD, rs1: b.rs1D, rs2: b.rs2D, rd: b.rdD,
               op: b.ALUOpD, cmd: b.ALUControlD, src: b.ALUSrcD, br: b.branchD,
               rw: b.regWriteD, mr: b.memReadD, mw: b.memWriteD, v: 1'b1};
    @(posedge clk);
    #1;
  endtask

  initial begin
    m = zero_e();
    // Reset with busy decode inputs.
    rst = 1;
    rand_inputs();
    b.stallE = 1;
    step(0);
    step(0);
    rst = 0;
    clear_inputs();
    #1;
    check_eq("rst_validE", 32'(b.validE), 0);
    check_eq("rst_lus", 32'(b.loadUseStall), 0);
    check_eq("rst_input1", b.input1, 0);

    // Plain load.
    b.rd1D = 5; b.rd2D = 7; b.rs1D = 1; b.rs2D = 2; b.rdD = 9;
    b.ALUOpD = 2; b.ALUControlD = 4'b0010; b.ALUSrcD = 0;
    step(1);
    check_eq("plain_in1", b.input1, 5);
    check_eq("plain_in2", b.input2, 7);
    check_eq("plain_cmd", 32'(b.ex_cmd), 2);
    check_eq("plain_op", 32'(b.ALUOp), 2);
    check_eq("plain_valid", 32'(b.validE), 1);

    // Forwarding priority on operand A.
    clear_inputs();
    b.rs1D = 3; b.rd1D = 55;
    step(1);
    b.rdM = 3; b.regWriteM = 1; b.aluResultM = 100;
    b.rdW = 3; b.regWriteW = 1; b.resultW = 200;
    #1 check_eq("fwd_m_first", b.input1, 100);
    b.regWriteM = 0;
    #1 check_eq("fwd_w", b.input1, 200);
    b.rs1D = 0; b.rd1D = 77;
    step(1);
    b.rdM = 0; b.rdW = 0; b.regWriteM = 1;
    #1 check_eq("fwd_r0", b.input1, 77);

    // Immediate operand 2 with forwarded store data.
    clear_inputs();
    b.ALUSrcD = 1; b.immD = 16; b.rs2D = 4; b.rd2D = 3;
    step(1);
    b.rdW = 4; b.regWriteW = 1; b.resultW = 9;
    #1 check_eq("imm_in2", b.input2, 16);
    check_eq("imm_store", b.writeDataE, 9);

    // Load-use bubble, then a load to r0 that must not stall.
    clear_inputs();
    b.memReadD = 1; b.rdD = 6; b.ALUOpD = 1;
    step(1);
    clear_inputs();
    b.rs1D = 1; b.rs2D = 6; b.ALUOpD = 2;
    #1 check_eq("lu_stall", 32'(b.loadUseStall), 1);
    step(1);
    check_eq("lu_valid", 32'(b.validE), 0);
    check_eq("lu_op", 32'(b.ALUOp), 0);
    b.memReadD = 1; b.rdD = 0;
    step(1);
    b.memReadD = 0;
    #1 check_eq("lu_r0", 32'(b.loadUseStall), 0);

    // Hold for three stalled cycles, then stall+flush gives a bubble.
    clear_inputs();
    b.rd1D = 32'h1234; b.ALUOpD = 2; b.ALUControlD = 4'h7; b.rdD = 5;
    step(1);
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      b.stallE = 1; b.flushE = 0;
      step(1);
    end
    check_eq("stall_cmd", 32'(b.ex_cmd), 7);
    check_eq("stall_valid", 32'(b.validE), 1);
    b.stallE = 1; b.flushE = 1;
    step(1);
    check_eq("flush_valid", 32'(b.validE), 0);

    // Random traffic with occasional reset.
    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      rst = ($urandom_range(0, 49) == 0);
      step(1);
    end
    rst = 0;
    clear_inputs();
    step(1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
